writeback_unit: RTL



---
 rtl/wb_pkg.sv | 43 ++++
 rtl/wb_fifo.sv | 59 +++++
 rtl/writeback_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and load-format helpers for the writeback unit.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = lo[0];
      F3_LW:         bad = (lo != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                         input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'b0, b};
      F3_LHU:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO: two ordered write ports, one read port, per-entry rd taps.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0,
  input  logic [4:0]            rd0,
  input  logic [31:0]           dat0,
  input  logic                  we1,
  input  logic [4:0]            rd1,
  input  logic [31:0]           dat1,
  input  logic                  re,
  output logic [4:0]            head_rd,
  output logic [31:0]           head_data,
  output logic [PW:0]           count,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [DEPTH-1:0][4:0] ent_rd
);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wptr, rptr, wptr1;
  logic [PW:0]       cnt_n;

  // we1 is only ever raised together with we0, so port 1 lands right after port 0
  assign wptr1 = wptr + PW'(1);
  assign cnt_n = count + {{PW{1'b0}}, we0} + {{PW{1'b0}}, we1} - {{PW{1'b0}}, re};

  always_ff @(posedge clk) begin
    if (we0) mem[wptr]  <= '{rd: rd0, data: dat0};
    if (we1) mem[wptr1] <= '{rd: rd1, data: dat1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(we0) + PW'(we1);
      rptr  <= rptr + PW'(re);
      count <= cnt_n;
    end
  end

  assign head_rd   = mem[rptr].rd;
  assign head_data = mem[rptr].data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rptr;
    assign ent_vld[i] = ({1'b0, off} < count);
    assign ent_rd[i]  = mem[i].rd;
  end

endmodule

// File: rtl/writeback_unit.sv
// Serialises ALU and load completions onto the single register-file write port.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic        in_ready,
  output logic        regwrite,
  output logic [4:0]  rdaddr,
  output logic [31:0] rddata,
  input  logic [4:0]  pend_addr,
  output logic        pend_hit,
  output logic        ld_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH - 2);

  logic [PW:0]            count;
  logic [DEPTH-1:0]       ent_vld;
  logic [DEPTH-1:0][4:0]  ent_rd;
  logic [4:0]             head_rd;
  logic [31:0]            head_data;
  logic                   empty, ld_acc, bad, ld_push, alu_push;
  logic                   p0v, p1v, we0, we1;
  wb_entry_t              ld_e, alu_e, p0, fw0;
  logic [DEPTH-1:0]       hit_vec;

  assign in_ready = (count <= CNT_MAX);
  assign empty    = (count == '0);

  assign ld_acc   = ld_valid & in_ready;
  assign bad      = ld_bad(ld_funct3, ld_addr_lo);
  assign ld_push  = ld_acc & ~bad & (ld_rd != 5'd0);
  assign alu_push = alu_valid & in_ready & (alu_rd != 5'd0);

  assign ld_e  = '{rd: ld_rd, data: ld_fmt(ld_funct3, ld_addr_lo, ld_rdata)};
  assign alu_e = '{rd: alu_rd, data: alu_data};

  // Compact pushes: the load is older, so it goes first when both are present
  assign p0v = ld_push | alu_push;
  assign p0  = ld_push ? ld_e : alu_e;
  assign p1v = ld_push & alu_push;

  // With the FIFO empty the oldest push bypasses straight to the output register
  assign we0 = empty ? p1v : p0v;
  assign fw0 = empty ? alu_e : p0;
  assign we1 = ~empty & p1v;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .we0       (we0),
    .rd0       (fw0.rd),
    .dat0      (fw0.data),
    .we1       (we1),
    .rd1       (alu_e.rd),
    .dat1      (alu_e.data),
    .re        (~empty),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite <= 1'b0;
      rdaddr   <= '0;
      rddata   <= '0;
      ld_err   <= 1'b0;
    end else begin
      ld_err <= ld_acc & bad;
      if (!empty) begin
        regwrite <= 1'b1;
        rdaddr   <= head_rd;
        rddata   <= head_data;
      end else if (p0v) begin
        regwrite <= 1'b1;
        rdaddr   <= p0.rd;
        rddata   <= p0.data;
      end else begin
        regwrite <= 1'b0;
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      hit_vec[i] = ent_vld[i] & (ent_rd[i] == pend_addr);
  end

  assign pend_hit = (pend_addr != 5'd0) &
                    ((|hit_vec) | (regwrite & (rdaddr == pend_addr)));

endmodule
